// File: rtl/audio_i2s_tx_pkg.sv
// audio_i2s_tx_pkg: audio frame constants shared by the I2S transmitter and the tone generators
package audio_i2s_tx_pkg;
    localparam int SAMPLE_W        = 16;
    localparam int MCLK_LOG2       = 2;
    localparam int SCK_LOG2        = 3;
    localparam int FRAME_LOG2      = 9;
    localparam int SLOT_W          = FRAME_LOG2 - 1 - SCK_LOG2;
    localparam int CAPTURE_CNT     = (1 << FRAME_LOG2) - 1;
    localparam int FIRST_DATA_SLOT = 1;
    typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/audio_clk_gen.sv
// audio_clk_gen: free-running frame counter producing MCLK/SCK/LRCK and slot/frame strobes
module audio_clk_gen
    import audio_i2s_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic              mclk_o,
    output logic              sck_o,
    output logic              lrck_o,
    output logic [SLOT_W-1:0] nxt_slot_o,
    output logic              nxt_ch_o,
    output logic              slot_end_o,
    output logic              frame_end_o
);
    logic [FRAME_LOG2-1:0] cnt_q, cnt_d;
    always_comb cnt_d = cnt_q + FRAME_LOG2'(1);
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    assign mclk_o      = cnt_q[MCLK_LOG2-1];
    assign sck_o       = cnt_q[SCK_LOG2-1];
    assign lrck_o      = cnt_q[FRAME_LOG2-1];
    // slot/channel the counter enters on the next edge, so data can be registered ahead of it
    assign nxt_slot_o  = cnt_d[FRAME_LOG2-2 -: SLOT_W];
    assign nxt_ch_o    = cnt_d[FRAME_LOG2-1];
    assign slot_end_o  = &cnt_q[SCK_LOG2-1:0];
    assign frame_end_o = cnt_q == FRAME_LOG2'(CAPTURE_CNT);
endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: captures left/right samples once per frame and serializes them as I2S
module audio_i2s_tx
    import audio_i2s_tx_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] audio_left,
    input  logic [SAMPLE_W-1:0] audio_right,
    input  logic                mute,
    output logic                audio_mclk,
    output logic                audio_lrck,
    output logic                audio_sck,
    output logic                audio_sdin,
    output logic                sample_req
);
    logic [SLOT_W-1:0] nxt_slot;
    logic              nxt_ch, slot_end, frame_end, in_data, sdin_q, sdin_d;
    sample_t           hold_l_q, hold_l_d, hold_r_q, hold_r_d, word, shifted;

    audio_clk_gen u_clk_gen (
        .clk         (clk),
        .rst         (rst),
        .mclk_o      (audio_mclk),
        .sck_o       (audio_sck),
        .lrck_o      (audio_lrck),
        .nxt_slot_o  (nxt_slot),
        .nxt_ch_o    (nxt_ch),
        .slot_end_o  (slot_end),
        .frame_end_o (frame_end)
    );

    always_comb begin
        hold_l_d = frame_end ? (mute ? '0 : audio_left)  : hold_l_q;
        hold_r_d = frame_end ? (mute ? '0 : audio_right) : hold_r_q;
        word     = nxt_ch ? hold_r_q : hold_l_q;
        // I2S one-slot delay: slot 1 carries the MSB
        shifted  = word << (nxt_slot - SLOT_W'(FIRST_DATA_SLOT));
        in_data  = nxt_slot >= SLOT_W'(FIRST_DATA_SLOT) && nxt_slot <= SLOT_W'(SAMPLE_W);
        sdin_d   = slot_end ? (in_data & shifted[SAMPLE_W-1]) : sdin_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_l_q <= '0;
            hold_r_q <= '0;
            sdin_q   <= 1'b0;
        end else begin
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            sdin_q   <= sdin_d;
        end
    end

    assign audio_sdin = sdin_q;
    assign sample_req = frame_end;
endmodule
